// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode encoding and counter/pointer width helper.
package fifo_pkg;

  typedef enum logic {
    FIFO_RD_REG  = 1'b0,
    FIFO_RD_FWFT = 1'b1
  } fifo_rd_mode_e;

  // Pointer/count width: one extra bit carries the wrap flag.
  function automatic int fifo_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Write/read handshake bundle for stream_fifo plus its status outputs.
interface stream_fifo_if import fifo_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CW = fifo_cw(DEPTH);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [CW-1:0]         count;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         max_level;

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, almost_full, almost_empty, max_level
  );

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, almost_full, almost_empty, max_level
  );
endinterface

// File: rtl/fifo_mem_2p.sv
// 1W1R register array: synchronous write, combinational read.
module fifo_mem_2p #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// Synchronous valid/ready FIFO with FWFT or registered read, occupancy flags,
// synchronous flush and sticky high-water mark.
module stream_fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  stream_fifo_if.slave  bus
);

  localparam int CW = fifo_cw(DEPTH);
  localparam int AW = CW - 1;
  localparam fifo_rd_mode_e RD_MODE = (FWFT != 0) ? FIFO_RD_FWFT : FIFO_RD_REG;
  localparam logic [CW-1:0] AFULL_LVL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("stream_fifo: AFULL_THRESH out of range 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("stream_fifo: AEMPTY_THRESH out of range 0..DEPTH-1");
  end

  logic [CW-1:0]         wr_ptr, rd_ptr, count_q, count_nxt, max_q;
  logic                  empty, full, push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // wr_ready depends only on registered state, so a pop never frees a slot
  // for a push in the same cycle.
  assign push = bus.wr_valid & ~full;
  assign pop  = bus.rd_ready & ~empty;

  always_comb begin
    count_nxt = count_q;
    if (push && !pop)      count_nxt = count_q + CW'(1);
    else if (pop && !push) count_nxt = count_q - CW'(1);
  end

  fifo_mem_2p #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push & rst_n & ~flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      max_q   <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      max_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      count_q <= count_nxt;
      if (count_nxt > max_q) max_q <= count_nxt;
    end
  end

  if (RD_MODE == FIFO_RD_FWFT) begin : g_fwft
    assign bus.rd_valid = ~empty;
    assign bus.rd_data  = head;
  end else begin : g_reg
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Output word is presented for exactly one cycle after each pop; data holds.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_valid_q <= 1'b0;
        rd_data_q  <= '0;
      end else if (flush) begin
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= pop;
        if (pop) rd_data_q <= head;
      end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
  end

  assign bus.wr_ready     = ~full;
  assign bus.count        = count_q;
  assign bus.max_level    = max_q;
  assign bus.almost_full  = (count_q >= AFULL_LVL);
  assign bus.almost_empty = (count_q <= AEMPTY_LVL);

endmodule

// File: tb/tb_stream_fifo.sv
// Drives an FWFT and a registered-read stream_fifo with identical stimulus and
// checks both against a queue-based reference model.
module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n, flush, wv, rr;
  logic [DW-1:0] wd;

  int errors = 0;
  int checks = 0;

  stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_f ();
  stream_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_r ();

  assign bus_f.wr_valid = wv;
  assign bus_f.wr_data  = wd;
  assign bus_f.rd_ready = rr;
  assign bus_r.wr_valid = wv;
  assign bus_r.wr_data  = wd;
  assign bus_r.rd_ready = rr;

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_f));

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_r (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus_r));

  always #5 clk = ~clk;

  // Reference model: contents as a queue, registered-read output as a latch
  // of the last word popped.
  logic [DW-1:0] q[$];
  int            max_m;
  logic          rv0;
  logic [DW-1:0] rd0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit            do_push, do_pop;
    logic [DW-1:0] h;
    if (!rst_n) begin
      q.delete();
      max_m = 0;
      rv0   = 1'b0;
      rd0   = '0;
    end else if (flush) begin
      q.delete();
      max_m = 0;
      rv0   = 1'b0;
    end else begin
      do_push = wv && (q.size() < DEPTH);
      do_pop  = rr && (q.size() > 0);
      if (do_pop) begin
        h   = q.pop_front();
        rv0 = 1'b1;
        rd0 = h;
      end else begin
        rv0 = 1'b0;
      end
      if (do_push) q.push_back(wd);
      if (q.size() > max_m) max_m = q.size();
    end
  endtask

  task automatic compare_all();
    int n;
    n = q.size();
    check("f_wr_ready",     32'(bus_f.wr_ready),     32'(n < DEPTH));
    check("f_rd_valid",     32'(bus_f.rd_valid),     32'(n > 0));
    if (n > 0) check("f_rd_data", bus_f.rd_data, q[0]);
    check("f_count",        32'(bus_f.count),        32'(n));
    check("f_almost_full",  32'(bus_f.almost_full),  32'(n >= AF));
    check("f_almost_empty", 32'(bus_f.almost_empty), 32'(n <= AE));
    check("f_max_level",    32'(bus_f.max_level),    32'(max_m));
    check("r_wr_ready",     32'(bus_r.wr_ready),     32'(n < DEPTH));
    check("r_rd_valid",     32'(bus_r.rd_valid),     32'(rv0));
    check("r_rd_data",      bus_r.rd_data,           rd0);
    check("r_count",        32'(bus_r.count),        32'(n));
    check("r_almost_full",  32'(bus_r.almost_full),  32'(n >= AF));
    check("r_almost_empty", 32'(bus_r.almost_empty), 32'(n <= AE));
    check("r_max_level",    32'(bus_r.max_level),    32'(max_m));
  endtask

  task automatic cycle();
    compare_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    rst_n = 1'b0; flush = 1'b0; wv = 1'b1; wd = 32'h55; rr = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    cycle();
    cycle();
    rst_n = 1'b1; wv = 1'b0;
    cycle();

    // Fill past full, then drain.
    for (int i = 0; i < 9; i++) begin
      wv = 1'b1; wd = 32'hA0 + 32'(i);
      cycle();
    end
    wv = 1'b0; rr = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    rr = 1'b0;

    // Steady push/pop at count 4 across pointer wrap.
    d = 32'h100;
    wv = 1'b1;
    for (int i = 0; i < 4; i++) begin wd = d; d++; cycle(); end
    rr = 1'b1;
    for (int i = 0; i < 20; i++) begin wd = d; d++; cycle(); end
    rr = 1'b0;

    // Top up to full, then push+pop at full, then push again.
    for (int i = 0; i < 5; i++) begin wd = d; d++; cycle(); end
    rr = 1'b1; wd = d; d++;
    cycle();
    rr = 1'b0; wd = d; d++;
    cycle();
    wv = 1'b0;
    cycle();

    // Flush, rebuild to 5, flush with a concurrent push, then reset with flush.
    flush = 1'b1; cycle(); flush = 1'b0;
    wv = 1'b1;
    for (int i = 0; i < 5; i++) begin wd = 32'hC0 + 32'(i); cycle(); end
    flush = 1'b1; wd = 32'hCF; cycle();
    flush = 1'b0; wv = 1'b0; cycle();
    rst_n = 1'b0; flush = 1'b1; cycle();
    rst_n = 1'b1; flush = 1'b0; cycle();

    // Randomised traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int ph;
      ph    = (i / 150) % 3;
      wv    = (ph == 0) ? ($urandom_range(0, 7) != 0) :
              (ph == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
      rr    = (ph == 1) ? ($urandom_range(0, 7) != 0) :
              (ph == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) != 0);
      wd    = $urandom;
      flush = ($urandom_range(0, 63) == 0);
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst_n = 1'b1; flush = 1'b0; wv = 1'b0; rr = 1'b0;
    cycle();
    compare_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
